serial_subtractor: RTL

Multi-cycle, parametrised N-bit subtractor that computes Y = A − B with a borrow-out. It processes STEP bits per clock, LSB first, with a registered borrow chain between chunks. It generalises the single-bit enabled half subtractor to WIDTH-bit operands, adds a start/busy/done handshake and stall-on-enable, and is the arithmetic building block for later datapath projects.

---
 rtl/serial_subtractor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: WIDTH-bit unsigned subtractor (Y = A - B) that handles
// STEP bits per clock, LSB first, with a registered borrow between chunks.
// Start/busy/done handshake; en=0 stalls every piece of state.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN adds a borrow-in port 'bin'
// that seeds the internal borrow, giving Y = A - B - bin.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // One full-subtractor cell; returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              brw_q, brw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              borrow_q, borrow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [STEP-1:0]       chunk_diff_s;
  logic [STEP:0]         chain_s;
  logic [WIDTH+STEP-1:0] a_ext_s;
  logic [WIDTH+STEP-1:0] b_ext_s;
  logic [WIDTH+STEP-1:0] r_ext_s;
  logic [WIDTH-1:0]      a_shift_s;
  logic [WIDTH-1:0]      b_shift_s;
  logic [WIDTH-1:0]      r_shift_s;
  logic                  bin_init_s;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bin_init_s = bin;
`else
  assign bin_init_s = 1'b0;
`endif

  // Ripple STEP full-subtractor cells over the current low chunk of the operands.
  always_comb begin
    chunk_diff_s = '0;
    chain_s      = '0;
    chain_s[0]   = brw_q;
    for (int i = 0; i < STEP; i++) begin
      {chain_s[i+1], chunk_diff_s[i]} = full_sub(a_q[i], b_q[i], chain_s[i]);
    end
  end

  // Operands shift right by one chunk; the new difference chunk enters at the top
  // of the result, so after N chunks the result is in natural bit order.
  always_comb begin
    a_ext_s   = {{STEP{1'b0}}, a_q};
    b_ext_s   = {{STEP{1'b0}}, b_q};
    r_ext_s   = {chunk_diff_s, r_q};
    a_shift_s = a_ext_s[WIDTH+STEP-1:STEP];
    b_shift_s = b_ext_s[WIDTH+STEP-1:STEP];
    r_shift_s = r_ext_s[WIDTH+STEP-1:STEP];
  end

  // Next-state and datapath update: load on accepted start, one chunk per enabled RUN edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          r_d     = '0;
          brw_d   = bin_init_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (en) begin
          a_d   = a_shift_s;
          b_d   = b_shift_s;
          r_d   = r_shift_s;
          brw_d = chain_s[STEP];
          if (cnt_q == LAST_CNT) begin
            state_d  = IDLE;
            y_d      = r_shift_s;
            borrow_d = chain_s[STEP];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Y      = y_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
